demux4_4_wr: RTL and testbench
==============================

Name: demux4_4_wr

Overview:
- Write-side counterpart of the 4-way, 4-bit source-select mux: steers one 4-bit value into one of four 4-bit destination slots, selected by a 2-bit code.
- Each slot is a registered holding cell with a full flag that its consumer clears.
- Producer side uses a valid/ready handshake. Sits on the multicycle datapath wherever results fan out to one of four sinks (e.g. write-back to four 4-bit latches).

Parameters:
- WIDTH, 4, data width per slot.
- OVERWRITE, 0, 0 = back-pressure when target slot full; 1 = always accept, overwrite, flag overrun.
- CNT_W, 8, width of the accepted-write counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer offers din/sel this cycle.
- in_ready  out  1  block accepts this cycle; combinational from sel, full, dest_clr, rst.
- sel  in  2  destination: 00->slot0, 01->slot1, 10->slot2, 11->slot3 (sel[1] is the high select bit).
- din  in  WIDTH  data to write.
- dest_clr  in  4  per-slot consumer ack; clears full[k].
- q0, q1, q2, q3  out  WIDTH each  slot contents, registered.
- full  out  4  per-slot occupied flag, registered.
- overrun  out  4  sticky per-slot overwrite-while-full flag; only settable when OVERWRITE=1.
- wr_count  out  CNT_W  number of accepted writes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clock edge): q0..q3=0, full=0, overrun=0, wr_count=0. While rst=1, in_ready=0 and dest_clr is ignored. Reset wins over every other event in the same cycle. Reset mid-transfer drops the offered word; nothing is partially written.
- Accept condition: acc = in_valid & in_ready.
- OVERWRITE=0: in_ready = ~rst & (~full[sel] | dest_clr[sel]). Readiness depends only on the addressed slot; other slots being full never stalls the producer.
- OVERWRITE=1: in_ready = ~rst.
- On acc, at the next edge:
  - q[sel] <= din and full[sel] <= 1.
  - wr_count <= wr_count+1, wrapping from all-ones to 0.
  - Write latency is one cycle: q/full are visible the cycle after the accepting edge.
- Overrun: if OVERWRITE=1, acc, full[sel]=1 and dest_clr[sel]=0, then overrun[sel] <= 1. Sticky until rst.
- dest_clr[k]=1 without a write to k: full[k] <= 0 at the next edge; q[k] holds its value and is not zeroed.
- Simultaneous dest_clr[k] and accepted write to k: the write wins, so full[k] stays 1 and q[k] takes din. No overrun is flagged.
- Multiple dest_clr bits may assert together; each clears independently.
- in_valid=0: no state change except clears. Changes to sel/din while in_valid=0 are don't-care.
- Producer rule: once in_valid=1 with in_ready=0, hold sel/din/in_valid stable until accepted. The bench checks this; RTL does not enforce it.
- No X propagation: sel is fully decoded, so every code maps to exactly one slot.

Decomposition:
- Shared package holds:
  - SEL_W=2, NUM_SLOTS=4.
  - Slot index constants SLOT0..SLOT3 (values 0..3), shared with the mux so both ends decode sel identically.
- One sub-module is natural: demux_slot, one holding cell (q, full, overrun logic for a single slot, with wr_en, clr, din). Instantiate four times.
- The decoder, in_ready and wr_count logic stay in the top level.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1, sel=10, din=4'hA -> q0..q3=0, full=0000, wr_count=0, in_ready=0 throughout.
- Basic steer (OVERWRITE=0): write sel=00/din=3, sel=01/din=5, sel=10/din=9, sel=11/din=C on consecutive cycles -> each accepted; the cycle after the last write, q0=3, q1=5, q2=9, q3=C, full=1111, wr_count=4.
- Back-pressure: slot2 full, offer sel=10/din=7 with dest_clr=0 -> in_ready=0 and q2 unchanged. Assert dest_clr[2] -> accepted that cycle, q2=7, full[2]=1. Concurrently sel=01 to an empty slot1 is accepted immediately.
- Overwrite (OVERWRITE=1): slot1 full with 5, write sel=01/din=E -> q1=E, overrun=0010. A later dest_clr[1] clears full[1] but overrun[1] stays 1 until rst.
- Simultaneous clear and write, same slot, same cycle -> full[k] stays 1, q[k]=new data, overrun unchanged. Counter wrap with CNT_W=3: after 8 accepted writes, wr_count=0.
- Reset mid-operation: rst asserted in the same cycle as an accepted-looking offer (in_valid=1, empty target) -> no write, all state 0 next cycle, wr_count=0.

Source files
------------

// File: rtl/demux4_4_wr_pkg.sv
// Shared select-code definitions for the 4-way write demux and its mux counterpart.
// Both ends decode sel through these constants so the slot mapping cannot drift.
package demux4_4_wr_pkg;

   localparam int SEL_W     = 2;
   localparam int NUM_SLOTS = 4;

   localparam logic [SEL_W-1:0] SLOT0 = 2'd0;
   localparam logic [SEL_W-1:0] SLOT1 = 2'd1;
   localparam logic [SEL_W-1:0] SLOT2 = 2'd2;
   localparam logic [SEL_W-1:0] SLOT3 = 2'd3;

   // Every code maps to exactly one slot, so no X can leak from a partial decode.
   function automatic logic [NUM_SLOTS-1:0] sel_decode(input logic [SEL_W-1:0] s);
      logic [NUM_SLOTS-1:0] oh;
      oh = '0;
      case (s)
         SLOT0: oh = 4'b0001;
         SLOT1: oh = 4'b0010;
         SLOT2: oh = 4'b0100;
         SLOT3: oh = 4'b1000;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux4_4_wr_slot.sv
// One destination holding cell: data register, occupied flag and sticky overrun flag.
// A write in the same cycle as a consumer clear wins and leaves the cell full.
module demux_slot
   import demux4_4_wr_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int OVERWRITE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] q_o,
   output logic             full_o,
   output logic             overrun_o
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             full_q, full_d;
   logic             ovr_q, ovr_d;

   always_comb begin
      q_d    = q_q;
      full_d = full_q;
      ovr_d  = ovr_q;
      if (wr_en_i) begin
         q_d    = din_i;
         full_d = 1'b1;
         // A clear arriving with the write means the old word was consumed.
         if ((OVERWRITE != 0) && full_q && !clr_i) begin
            ovr_d = 1'b1;
         end
      end else if (clr_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         full_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         full_q <= full_d;
         ovr_q  <= ovr_d;
      end
   end

   assign q_o       = q_q;
   assign full_o    = full_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/demux4_4_wr.sv
// 4-way, 4-bit write demux: steers din into the slot picked by sel under valid/ready,
// with per-slot consumer clears and a wrapping accepted-write counter.
module demux4_4_wr
   import demux4_4_wr_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int OVERWRITE = 0,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SEL_W-1:0]     sel,
   input  logic [WIDTH-1:0]     din,
   input  logic [NUM_SLOTS-1:0] dest_clr,
   output logic [WIDTH-1:0]     q0,
   output logic [WIDTH-1:0]     q1,
   output logic [WIDTH-1:0]     q2,
   output logic [WIDTH-1:0]     q3,
   output logic [NUM_SLOTS-1:0] full,
   output logic [NUM_SLOTS-1:0] overrun,
   output logic [CNT_W-1:0]     wr_count
);

   logic [NUM_SLOTS-1:0] sel_oh;
   logic [NUM_SLOTS-1:0] wr_en;
   logic [NUM_SLOTS-1:0] full_w;
   logic [NUM_SLOTS-1:0] ovr_w;
   logic [WIDTH-1:0]     q_w [NUM_SLOTS];
   logic                 ready_w;
   logic                 acc;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Readiness looks only at the addressed slot so a full neighbour never stalls.
   always_comb begin
      sel_oh  = sel_decode(sel);
      ready_w = 1'b0;
      if (rst) begin
         ready_w = 1'b0;
      end else if (OVERWRITE != 0) begin
         ready_w = 1'b1;
      end else begin
         ready_w = ~full_w[sel] | dest_clr[sel];
      end
      acc   = in_valid & ready_w;
      wr_en = acc ? sel_oh : '0;
      cnt_d = acc ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
      demux_slot #(
         .WIDTH     (WIDTH),
         .OVERWRITE (OVERWRITE)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .wr_en_i   (wr_en[k]),
         .clr_i     (dest_clr[k]),
         .din_i     (din),
         .q_o       (q_w[k]),
         .full_o    (full_w[k]),
         .overrun_o (ovr_w[k])
      );
   end

   assign in_ready = ready_w;
   assign q0       = q_w[0];
   assign q1       = q_w[1];
   assign q2       = q_w[2];
   assign q3       = q_w[3];
   assign full     = full_w;
   assign overrun  = ovr_w;
   assign wr_count = cnt_q;

endmodule

// File: tb/tb_demux4_4_wr.sv
// Bench for demux4_4_wr: a back-pressure instance and an overwrite instance (3-bit counter),
// each tracked by a slot-array model and compared on every falling edge.
module tb_demux4_4_wr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [2];
   logic       vld [2];
   logic [1:0] sl  [2];
   logic [3:0] dn  [2];
   logic [3:0] clr [2];
   logic       rdy [2];
   logic [3:0] oq  [2][4];
   logic [3:0] ofull [2];
   logic [3:0] oovr  [2];
   logic [7:0] cnt0;
   logic [2:0] cnt1;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   demux4_4_wr #(.WIDTH(4), .OVERWRITE(0), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst(rst[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
      .sel(sl[0]), .din(dn[0]), .dest_clr(clr[0]),
      .q0(oq[0][0]), .q1(oq[0][1]), .q2(oq[0][2]), .q3(oq[0][3]),
      .full(ofull[0]), .overrun(oovr[0]), .wr_count(cnt0)
   );

   demux4_4_wr #(.WIDTH(4), .OVERWRITE(1), .CNT_W(3)) u_dut1 (
      .clk(clk), .rst(rst[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
      .sel(sl[1]), .din(dn[1]), .dest_clr(clr[1]),
      .q0(oq[1][0]), .q1(oq[1][1]), .q2(oq[1][2]), .q3(oq[1][3]),
      .full(ofull[1]), .overrun(oovr[1]), .wr_count(cnt1)
   );

   // Reference model: plain per-slot arrays updated from the rules at each rising edge.
   int mq    [2][4];
   bit mfull [2][4];
   bit movr  [2][4];
   int mcnt  [2];
   bit macc  [2];

   function automatic bit m_ready(input int d);
      if (rst[d]) return 1'b0;
      if (d == 1) return 1'b1;
      return !mfull[d][sl[d]] || clr[d][sl[d]];
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst[d]) begin
            macc[d] = 1'b0;
            mcnt[d] = 0;
            for (int k = 0; k < 4; k++) begin
               mq[d][k] = 0; mfull[d][k] = 1'b0; movr[d][k] = 1'b0;
            end
         end else begin
            macc[d] = vld[d] && m_ready(d);
            for (int k = 0; k < 4; k++) begin
               if (macc[d] && (int'(sl[d]) == k)) begin
                  if (d == 1 && mfull[d][k] && !clr[d][k]) movr[d][k] = 1'b1;
                  mq[d][k]    = int'(dn[d]);
                  mfull[d][k] = 1'b1;
               end else if (clr[d][k]) begin
                  mfull[d][k] = 1'b0;
               end
            end
            if (macc[d]) mcnt[d] = (mcnt[d] + 1) % ((d == 0) ? 256 : 8);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_in_ready", d), int'(rdy[d]), int'(m_ready(d)));
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("d%0d_q%0d", d, k), int'(oq[d][k]), mq[d][k]);
               chk($sformatf("d%0d_full%0d", d, k), int'(ofull[d][k]), int'(mfull[d][k]));
               chk($sformatf("d%0d_ovr%0d", d, k), int'(oovr[d][k]), int'(movr[d][k]));
            end
            chk($sformatf("d%0d_wr_count", d), (d == 0) ? int'(cnt0) : int'(cnt1), mcnt[d]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drv(input int d, input bit v, input int s, input int x, input int c);
      vld[d] = v;
      sl[d]  = 2'(s);
      dn[d]  = 4'(x);
      clr[d] = 4'(c);
   endtask

   initial begin
      int steer [4];
      steer = '{3, 5, 9, 12};
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         drv(d, 0, 0, 0, 0);
      end

      // Reset held two cycles with a live offer
      drv(0, 1, 2, 10, 0);
      tick();
      armed = 1'b1;
      #1 chk("lit_rst_ready_c1", int'(rdy[0]), 0);
      tick();
      #1 chk("lit_rst_ready_c2", int'(rdy[0]), 0);
      chk("lit_rst_q2", int'(oq[0][2]), 0);
      chk("lit_rst_full", int'(ofull[0]), 0);
      chk("lit_rst_cnt", int'(cnt0), 0);
      rst[0] = 1'b0; rst[1] = 1'b0;
      drv(0, 0, 0, 0, 0);
      tick();

      // Basic steer into all four slots
      for (int i = 0; i < 4; i++) begin
         drv(0, 1, i, steer[i], 0);
         #1 chk($sformatf("lit_steer_ready%0d", i), int'(rdy[0]), 1);
         tick();
      end
      drv(0, 0, 0, 0, 0);
      chk("lit_steer_q0", int'(oq[0][0]), 4'h3);
      chk("lit_steer_q1", int'(oq[0][1]), 4'h5);
      chk("lit_steer_q2", int'(oq[0][2]), 4'h9);
      chk("lit_steer_q3", int'(oq[0][3]), 4'hC);
      chk("lit_steer_full", int'(ofull[0]), 4'hF);
      chk("lit_steer_cnt", int'(cnt0), 4);

      // Back-pressure on a full slot, released by its clear
      drv(0, 1, 2, 7, 0);
      #1 chk("lit_bp_ready", int'(rdy[0]), 0);
      tick();
      chk("lit_bp_q2_held", int'(oq[0][2]), 4'h9);
      drv(0, 1, 2, 7, 4'b0100);
      #1 chk("lit_bp_ready_clr", int'(rdy[0]), 1);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("lit_bp_q2", int'(oq[0][2]), 4'h7);
      chk("lit_bp_full", int'(ofull[0]), 4'hF);
      drv(0, 0, 0, 0, 4'b0010);
      tick();
      drv(0, 1, 1, 6, 0);
      #1 chk("lit_empty_slot_ready", int'(rdy[0]), 1);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("lit_empty_slot_q1", int'(oq[0][1]), 6);
      chk("lit_empty_slot_cnt", int'(cnt0), 6);

      // Overwrite instance: overrun, sticky across clear, clear+write same slot, wrap
      drv(1, 1, 1, 5, 0);
      tick();
      drv(1, 1, 1, 14, 0);
      #1 chk("lit_ow_ready", int'(rdy[1]), 1);
      tick();
      drv(1, 0, 0, 0, 0);
      chk("lit_ow_q1", int'(oq[1][1]), 4'hE);
      chk("lit_ow_ovr", int'(oovr[1]), 4'b0010);
      drv(1, 0, 0, 0, 4'b0010);
      tick();
      drv(1, 0, 0, 0, 0);
      chk("lit_ow_clr_full", int'(ofull[1]), 0);
      chk("lit_ow_ovr_sticky", int'(oovr[1]), 4'b0010);
      chk("lit_ow_q1_kept", int'(oq[1][1]), 4'hE);
      drv(1, 1, 3, 1, 0);
      tick();
      drv(1, 1, 3, 6, 4'b1000);
      tick();
      drv(1, 0, 0, 0, 0);
      chk("lit_clrwr_full", int'(ofull[1]), 4'b1000);
      chk("lit_clrwr_q3", int'(oq[1][3]), 6);
      chk("lit_clrwr_ovr", int'(oovr[1]), 4'b0010);
      for (int i = 0; i < 3; i++) begin
         drv(1, 1, 0, i, 0);
         tick();
      end
      drv(1, 0, 0, 0, 0);
      chk("lit_cnt_seven", int'(cnt1), 7);
      drv(1, 1, 2, 3, 0);
      tick();
      drv(1, 0, 0, 0, 0);
      chk("lit_cnt_wrap", int'(cnt1), 0);

      // Reset colliding with an acceptable offer
      drv(0, 0, 0, 0, 4'hF);
      tick();
      rst[0] = 1'b1;
      drv(0, 1, 0, 11, 0);
      #1 chk("lit_midrst_ready", int'(rdy[0]), 0);
      tick();
      rst[0] = 1'b0;
      drv(0, 0, 0, 0, 0);
      chk("lit_midrst_q0", int'(oq[0][0]), 0);
      chk("lit_midrst_full", int'(ofull[0]), 0);
      chk("lit_midrst_cnt", int'(cnt0), 0);

      // Random traffic; a stalled offer is held until it is taken or reset drops it
      for (int n = 0; n < 3000; n++) begin
         for (int d = 0; d < 2; d++) begin
            bit held;
            held = vld[d] && !macc[d] && !rst[d];
            if (!held) begin
               vld[d] = ($urandom_range(0, 9) < 6);
               sl[d]  = 2'($urandom_range(0, 3));
               dn[d]  = 4'($urandom_range(0, 15));
            end
            clr[d] = 4'($urandom & $urandom);
            rst[d] = ($urandom_range(0, 99) == 0);
         end
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0;
         drv(d, 0, 0, 0, 0);
      end
      tick();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
